// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table and segment bit order.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_t SEG_OFF = 7'h00;

  // Active-high glyphs; bit i of each entry is segment a+i. Entry 15 first.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sevenseg_scanner_if.sv
// Display-port bundle: content inputs from the output-port register, pin-level outputs.
interface sevenseg_scanner_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_mask;
  logic                lz_en;
  logic                en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;

  modport master (output value, dp_mask, lz_en, en, input seg, dp, an);
  modport slave  (input value, dp_mask, lz_en, en, output seg, dp, an);
endinterface

// File: rtl/hex7seg.sv
// Combinational nibble-to-segment decoder, active-high, output in SEG_x bit order.
module hex7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  seg_t raw_s;

  // Table lookup, then place each glyph bit at its segment position
  always_comb begin
    raw_s        = HEX7_TABLE[nibble_i];
    seg_o        = SEG_OFF;
    seg_o[SEG_A] = raw_s[0];
    seg_o[SEG_B] = raw_s[1];
    seg_o[SEG_C] = raw_s[2];
    seg_o[SEG_D] = raw_s[3];
    seg_o[SEG_E] = raw_s[4];
    seg_o[SEG_F] = raw_s[5];
    seg_o[SEG_G] = raw_s[6];
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed hex display driver; content is snapshotted once per frame so digits never tear.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  sevenseg_scanner_if.slave  bus
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PCNT_W = $clog2(SCAN_DIV);

  localparam logic [DIGITS-1:0] AN_PIN_OFF  = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_PIN_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_PIN_OFF  = SEG_ACTIVE_LOW;

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_val_q, snap_val_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                snap_lz_q, snap_lz_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick_s;
  logic                lit_s;
  logic [3:0]          nibble_s;
  seg_t                seg_hex_s;
  seg_t                seg_hi_s;
  logic [DIGITS-1:0]   lz_blank_s;
  logic                zero_run_s;
  logic [DIGITS-1:0]   an_hot_s;

  hex7seg u_hex7seg (
    .nibble_i (nibble_s),
    .seg_o    (seg_hex_s)
  );

  // Slot prescaler, digit index and end-of-frame snapshot
  always_comb begin
    tick_s     = (pcnt_q == PCNT_W'(SCAN_DIV - 1));
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    if (tick_s) begin
      pcnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d      = '0;
        snap_val_d = bus.value;
        snap_dp_d  = bus.dp_mask;
        snap_lz_d  = bus.lz_en;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      pcnt_d = pcnt_q + PCNT_W'(1);
      idx_d  = idx_q;
    end
  end

  // A digit above 0 is suppressed when it and every digit to its left are zero
  always_comb begin
    zero_run_s = 1'b1;
    lz_blank_s = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run_s    = zero_run_s & (snap_val_q[4*k +: 4] == 4'h0);
      lz_blank_s[k] = zero_run_s & snap_lz_q;
    end
  end

  if (BLANK_CYC == 0) begin : g_no_blank
    assign lit_s = 1'b1;
  end else begin : g_blank
    assign lit_s = (pcnt_q >= PCNT_W'(BLANK_CYC));
  end

  // Next pin values for the current slot, with polarity applied
  always_comb begin
    nibble_s = snap_val_q[4*idx_q +: 4];
    an_hot_s = DIGITS'(1) << idx_q;
    if (lz_blank_s[idx_q]) begin
      seg_hi_s = SEG_OFF;
    end else begin
      seg_hi_s = seg_hex_s;
    end
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_hi_s;
      dp_d  = ~snap_dp_q[idx_q];
    end else begin
      seg_d = seg_hi_s;
      dp_d  = snap_dp_q[idx_q];
    end
    if (bus.en && lit_s) begin
      an_d = AN_ACTIVE_LOW ? ~an_hot_s : an_hot_s;
    end else begin
      an_d = AN_PIN_OFF;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      seg_q      <= SEG_PIN_OFF;
      dp_q       <= DP_PIN_OFF;
      an_q       <= AN_PIN_OFF;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner: scenario tasks checked against a cycle-count reference model.
module tb_sevenseg_scanner;

  localparam int DIGITS    = 8;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sevenseg_scanner_if #(.DIGITS(DIGITS)) bus ();

  sevenseg_scanner #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Pin-level (active-low) glyphs {g,f,e,d,c,b,a} for 0..F
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: cycles since reset release plus the frame snapshot in effect
  int          m_n = 0;
  logic [31:0] m_val = 32'd0;
  logic [7:0]  m_dp = 8'd0;
  logic        m_lz = 1'b0;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  int          exp_idx;
  int          exp_pc;

  task automatic model_reset();
    m_n = 0; m_val = 32'd0; m_dp = 8'd0; m_lz = 1'b0;
  endtask

  task automatic tick_model();
    int s;
    logic [31:0] cv;
    logic [7:0] cdp;
    logic clz, cen, blank;
    logic [3:0] nib;
    s = m_n; cv = bus.value; cdp = bus.dp_mask; clz = bus.lz_en; cen = bus.en;
    @(posedge clk);
    #1;
    exp_idx = (s / SCAN_DIV) % DIGITS;
    exp_pc  = s % SCAN_DIV;
    if (cen && exp_pc >= BLANK_CYC) exp_an = ~(8'd1 << exp_idx);
    else exp_an = 8'hFF;
    nib = 4'((m_val >> (4 * exp_idx)) & 32'hF);
    blank = m_lz && (exp_idx > 0) && ((m_val >> (4 * exp_idx)) == 32'd0);
    exp_seg = blank ? 7'b1111111 : seg_tab[nib];
    exp_dp = ~m_dp[exp_idx];
    if (s % FRAME == FRAME - 1) begin
      m_val = cv; m_dp = cdp; m_lz = clz;
    end
    m_n = s + 1;
  endtask

  task automatic align_frame();
    while (m_n % FRAME != 0) tick_model();
  endtask

  task automatic test_reset();
    bus.value = 32'd0; bus.dp_mask = 8'd0; bus.lz_en = 1'b0; bus.en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%b exp=%b", bus.an, 8'hFF); end
    checks++; if (bus.seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b exp=%b", bus.seg, 7'h7F); end
    checks++; if (bus.dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", bus.dp); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL boot_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL boot_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
      end
      if (i == 0) begin
        checks++; if (bus.an !== 8'hFF) begin failures++; $display("FAIL boot_blank got=%b exp=11111111", bus.an); end
      end
      if (i >= 1 && i <= 3) begin
        checks++; if (bus.an !== 8'hFE || bus.seg !== 7'b1000000) begin
          failures++; $display("FAIL boot_digit0 i=%0d got an=%b seg=%b exp an=11111110 seg=1000000", i, bus.an, bus.seg);
        end
      end
    end
  endtask

  task automatic test_hex();
    align_frame();
    bus.value = 32'h12345678; bus.lz_en = 1'b0; bus.dp_mask = 8'h00; bus.en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL hex_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL hex_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
        checks++; if (bus.dp !== exp_dp) begin failures++; $display("FAIL hex_dp i=%0d got=%b exp=%b", i, bus.dp, exp_dp); end
        if (i >= FRAME && exp_idx == 0) begin
          checks++; if (bus.seg !== 7'b0000000) begin failures++; $display("FAIL hex_digit0 got=%b exp=0000000", bus.seg); end
        end
        if (i >= FRAME && exp_idx == 7) begin
          checks++; if (bus.seg !== 7'b1111001) begin failures++; $display("FAIL hex_digit7 got=%b exp=1111001", bus.seg); end
        end
      end
    end
  endtask

  task automatic test_lz();
    align_frame();
    bus.value = 32'h000000A0; bus.lz_en = 1'b1; bus.dp_mask = 8'h01; bus.en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL lz_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL lz_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
        checks++; if (bus.dp !== exp_dp) begin failures++; $display("FAIL lz_dp i=%0d got=%b exp=%b", i, bus.dp, exp_dp); end
        if (i >= FRAME && exp_idx == 0) begin
          checks++; if (bus.seg !== 7'b1000000 || bus.dp !== 1'b0) begin
            failures++; $display("FAIL lz_digit0 got seg=%b dp=%b exp seg=1000000 dp=0", bus.seg, bus.dp);
          end
        end
        if (i >= FRAME && exp_idx == 1) begin
          checks++; if (bus.seg !== 7'b0001000) begin failures++; $display("FAIL lz_digit1 got=%b exp=0001000", bus.seg); end
        end
        if (i >= FRAME && exp_idx >= 2) begin
          checks++; if (bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
            failures++; $display("FAIL lz_blank idx=%0d got seg=%b dp=%b exp seg=1111111 dp=1", exp_idx, bus.seg, bus.dp);
          end
        end
      end
    end
  endtask

  task automatic test_no_tear();
    align_frame();
    bus.value = 32'h11111111; bus.lz_en = 1'b0; bus.dp_mask = 8'h00; bus.en = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == FRAME + 3 * SCAN_DIV + 1) bus.value = 32'h22222222;
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL tear_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL tear_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
        if (i >= FRAME && i < 2 * FRAME) begin
          checks++; if (bus.seg !== 7'b1111001) begin failures++; $display("FAIL tear_old i=%0d got=%b exp=1111001", i, bus.seg); end
        end
        if (i >= 2 * FRAME) begin
          checks++; if (bus.seg !== 7'b0100100) begin failures++; $display("FAIL tear_new i=%0d got=%b exp=0100100", i, bus.seg); end
        end
      end
    end
  endtask

  task automatic test_enable();
    align_frame();
    bus.en = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == FRAME + 5 * SCAN_DIV) bus.en = 1'b1;
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL en_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (i <= FRAME + 5 * SCAN_DIV) begin
        checks++; if (bus.an !== 8'hFF) begin failures++; $display("FAIL en_off i=%0d got=%b exp=11111111", i, bus.an); end
      end else if (i <= FRAME + 6 * SCAN_DIV - 1) begin
        checks++; if (bus.an !== 8'b11011111) begin failures++; $display("FAIL en_digit5 i=%0d got=%b exp=11011111", i, bus.an); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bus.value = 32'h12345678; bus.lz_en = 1'b0; bus.en = 1'b1;
    guard = 0;
    do begin
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL rmid_pre_an n=%0d got=%b exp=%b", m_n, bus.an, exp_an); end
      guard++;
    end while (!(exp_idx == 4 && exp_pc == 1) && guard < 3 * FRAME);
    checks++; if (guard >= 3 * FRAME) begin failures++; $display("FAIL rmid_reach got=timeout exp=idx4"); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      failures++; $display("FAIL rmid_async got an=%b seg=%b dp=%b exp an=11111111 seg=1111111 dp=1", bus.an, bus.seg, bus.dp);
    end
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL rmid_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL rmid_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
      end
      if (i == 1) begin
        checks++; if (bus.an !== 8'hFE || bus.seg !== 7'b1000000) begin
          failures++; $display("FAIL rmid_restart got an=%b seg=%b exp an=11111110 seg=1000000", bus.an, bus.seg);
        end
      end
    end
  endtask

  task automatic test_random();
    align_frame();
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.value   = $urandom >> $urandom_range(0, 31);
        bus.dp_mask = 8'($urandom);
        bus.lz_en   = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
      tick_model();
      checks++; if (bus.an !== exp_an) begin failures++; $display("FAIL rand_an i=%0d got=%b exp=%b", i, bus.an, exp_an); end
      if (exp_an != 8'hFF) begin
        checks++; if (bus.seg !== exp_seg) begin failures++; $display("FAIL rand_seg i=%0d got=%b exp=%b", i, bus.seg, exp_seg); end
        checks++; if (bus.dp !== exp_dp) begin failures++; $display("FAIL rand_dp i=%0d got=%b exp=%b", i, bus.dp, exp_dp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_lz();
    test_no_tear();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scanner.md
# sevenseg_scanner

Time-multiplexed seven-segment display driver that consumes the 32-bit `oport` word of the memory-mapped output port and shows it as eight hexadecimal digits on the board's common-anode display. It snapshots the value once per scan frame so digits never tear. It also provides leading-zero suppression, per-digit decimal points and an anti-ghosting blank interval. It sits between the output port register and the FPGA display pins.

## Interface
- `DIGITS`, 8: number of digits scanned; `value` width is 4*DIGITS.
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
- `SEG_ACTIVE_LOW`, 1: 1 means `seg`/`dp` pins are active-low.
- `AN_ACTIVE_LOW`, 1: 1 means `an` pins are active-low.
- `clk`  in  1  system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `value`  in  4*DIGITS  word to display; nibble k is digit k, and digit 0 is rightmost.
- `dp_mask`  in  DIGITS  bit k lights the decimal point of digit k.
- `lz_en`  in  1  enables leading-zero suppression.
- `en`  in  1  display enable; when low, all anodes are inactive.
- `seg`  out  7  segments {g,f,e,d,c,b,a}; registered.
- `dp`  out  1  decimal point; registered.
- `an`  out  DIGITS  digit anodes, one-hot when active; registered.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (pcnt == SCAN_DIV-1).
- Digit index `idx` counts 0..DIGITS-1. It advances on `tick` and wraps from DIGITS-1 to 0.
- Snapshot: on `tick` with idx == DIGITS-1, register `value`, `dp_mask` and `lz_en` into `snap_val`, `snap_dp` and `snap_lz`. These registers are the only source for display content. Changes to the inputs mid-frame are invisible until the next frame.
- Digit decode: nibble = snap_val[4*idx +: 4], hex-decoded to active-high segments (0→0111111, 1→0000110, …, F→1110001).
- Leading-zero suppression: if snap_lz is set, digit k>0 is blank when every nibble from k to DIGITS-1 is zero. Digit 0 is never suppressed. A blank digit drives all segments off but its `dp` still follows snap_dp.
- Anode select: `an` is one-hot at idx when en==1 and pcnt ≥ BLANK_CYC. Otherwise all anodes are inactive.
- Output polarity is applied at the output register per the `SEG_ACTIVE_LOW`/`AN_ACTIVE_LOW` parameters.
- `en` gates only `an`. Counters and snapshots run regardless of `en`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pcnt=0, idx=0, snap_val=0, snap_dp=0, snap_lz=0.
  - an = all inactive, seg = all off, dp = off.
- Outputs are registered, so `seg`/`dp`/`an` reflect the pcnt/idx state with 1 cycle of latency.
- The first slot after reset shows digit 0 of snap_val=0, i.e. "0", once pcnt ≥ BLANK_CYC and en=1.
- The first real snapshot is taken on the tick ending slot DIGITS-1. Worst-case latency from a `value` change to its visibility is DIGITS*SCAN_DIV+1 cycles.
- Frame period is DIGITS*SCAN_DIV cycles. Each digit is lit for (SCAN_DIV-BLANK_CYC) cycles per frame.
- Simultaneous `tick` and input change: the snapshot captures the input value present on that clock edge.
- Reset asserted mid-slot forces all outputs inactive immediately, without waiting for a clock edge.
- BLANK_CYC=0: anodes are never forced off inside a slot.

## Structure
- Package `sevenseg_pkg` holds:
  - the 16-entry hex-to-segment constant table;
  - the segment bit-order localparams (SEG_A..SEG_G);
  - the all-off segment constant.
- Sub-module `hex7seg` is the combinational nibble-to-segment decoder using the package table; the top instantiates it once.
- Leading-zero detection is a combinational loop over snap_val inside the top.

## Test plan
Bench parameters for all scenarios: DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, both polarities active-low.

- Reset, then en=1 and value=0: after reset release, an=11111111 for the blank cycle. Then an=11111110 and seg=1000000 ("0") for 3 cycles. Each slot steps to the next anode one position left.
- value=32'h12345678, lz_en=0, held for 2 frames: in the second frame, digits 0..7 show 8,7,6,5,4,3,2,1. Digit 0 shows seg=0000000 ("8"), and digit 7 shows seg=1111001 ("1").
- value=32'h000000A0, lz_en=1, dp_mask=8'h01:
  - digit 0 shows "0" with dp=0 (lit);
  - digit 1 shows "A" (0001000);
  - digits 2..7 have seg=1111111 and dp=1.
- value changed from 32'h11111111 to 32'h22222222 mid-frame (during idx=3): the rest of that frame still shows "1". The next frame shows "2" on every digit.
- en=0 for one full frame: an=11111111 throughout, while idx keeps advancing. Raising en at idx=5 lights anode 5 after the slot's blank cycle.
- reset_n pulsed low mid-slot at idx=4: an/seg/dp go inactive in the same cycle. After release the scan restarts at idx=0 with snap_val=0.
